// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the board push-button conditioner and other board-input blocks.
// Debounce FSM encodings and the 50 MHz default debounce interval.
package key_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 1000000;
  localparam int unsigned DEBOUNCE_CNT_W        = 20;

  typedef enum logic [1:0] {
    UP     = 2'b00,
    CHK_DN = 2'b01,
    DOWN   = 2'b10,
    CHK_UP = 2'b11
  } deb_state_e;

endpackage

// File: rtl/key_conditioner_debounce_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM with stability counter,
// registered level and press/release strobes.
module key_debounce_channel
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_key_i,
  output logic key_o,
  output logic key_down_o,
  output logic key_up_o,
  output logic edge_c_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             pressed_s;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             down_q, down_d;
  logic             up_q, up_d;

  // Raw buttons idle high, so the synchronizer resets to the released level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_key_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= UP;
      cnt_q   <= '0;
      key_q   <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  // Any single-cycle reversion during a check state abandons the attempt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    down_d  = 1'b0;
    up_d    = 1'b0;
    case (state_q)
      UP: begin
        if (pressed_s) begin
          cnt_d   = CNT_ONE;
          state_d = CHK_DN;
        end
      end
      CHK_DN: begin
        if (!pressed_s) begin
          cnt_d   = '0;
          state_d = UP;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DOWN;
          key_d   = 1'b1;
          down_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DOWN: begin
        if (!pressed_s) begin
          cnt_d   = CNT_ONE;
          state_d = CHK_UP;
        end
      end
      CHK_UP: begin
        if (pressed_s) begin
          cnt_d   = '0;
          state_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = UP;
          key_d   = 1'b0;
          up_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = UP;
    endcase
  end

  assign key_o      = key_q;
  assign key_down_o = down_q;
  assign key_up_o   = up_q;
  // Next-cycle strobe, lets the top register `changed` in step with the pulses.
  assign edge_c_o   = down_d | up_d;

endmodule

// File: rtl/key_conditioner.sv
// Board push-button front end: NUM_KEYS independent debounce channels plus a
// combined registered change strobe for redraw triggering.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_up,
  output logic                changed
);

  logic [NUM_KEYS-1:0] edge_c;
  logic                changed_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .raw_key_i (raw_keys[i]),
      .key_o     (keys[i]),
      .key_down_o(key_down[i]),
      .key_up_o  (key_up[i]),
      .edge_c_o  (edge_c[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) changed_q <= 1'b0;
    else        changed_q <= |edge_c;
  end

  assign changed = changed_q;

endmodule
